// File: rtl/servo_pulse_decoder.sv
// servo_pulse_decoder
//   Measures the high time of a servo PWM pulse in clock counts and maps it
//   back to an angle by inverting width = SCALE*angle + OFFSET.
//   The result is a truncating restoring divide that takes a fixed number of cycles.
//
// Ports
//   clk          system clock (single clock domain)
//   rst_n        asynchronous active-low reset
//   pwm_in       servo pulse, asynchronous to clk
//   angle        last decoded angle, 0..MAX_ANGLE
//   angle_valid  one-cycle strobe when angle/width/range_err update
//   width        raw high time of the last pulse, in clocks
//   range_err    last pulse was out of range and the angle was clamped
//   signal_lost  no rising edge for TIMEOUT clocks
//
// Timing: angle_valid is high in cycle F+11, where F is the first cycle the
// synchronized input reads 0 after reading 1.
module servo_pulse_decoder #(
  parameter int unsigned OFFSET    = 60000,
  parameter int unsigned SCALE     = 944,
  parameter int unsigned MAX_ANGLE = 360,
  parameter int unsigned TIMEOUT   = 4000000,
  parameter int unsigned CNT_W     = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pwm_in,
  output logic [8:0]       angle,
  output logic             angle_valid,
  output logic [CNT_W-1:0] width,
  output logic             range_err,
  output logic             signal_lost
);

  // The upper legal bound is computed at 64 bits so it never wraps.
  localparam longint unsigned BOUND = longint'(OFFSET) + longint'(SCALE) * longint'(MAX_ANGLE + 1);
  localparam int unsigned     LW    = $clog2(TIMEOUT + 1);
  localparam logic [LW-1:0]   TMO   = LW'(TIMEOUT);
  localparam logic [CNT_W-1:0] CMAX = {CNT_W{1'b1}};
  localparam logic [8:0]      AMAX  = 9'(MAX_ANGLE);

  typedef enum logic [2:0] {IDLE, HIGH, CALC, DIV, DONE} state_t;

  // ---------------------------------------------------------------------------
  // Synchronizer and edge detect
  // ---------------------------------------------------------------------------
  // The chain resets to 1. A pulse that is already high when reset is released
  // then produces no rise. Measurement starts only on a genuine low-to-high edge.
  logic s1, pwm_s, pwm_d;
  logic rise, fall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1    <= 1'b1;
      pwm_s <= 1'b1;
      pwm_d <= 1'b1;
    end else begin
      s1    <= pwm_in;
      pwm_s <= s1;
      pwm_d <= pwm_s;
    end
  end

  assign rise = pwm_s & ~pwm_d;
  assign fall = ~pwm_s & pwm_d;

  // ---------------------------------------------------------------------------
  // Measurement / divide FSM
  // ---------------------------------------------------------------------------
  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [CNT_W-1:0] width_r, width_r_nx;
  logic [CNT_W-1:0] rem, rem_nx;
  logic [8:0]       q, q_nx;
  logic [3:0]       step, step_nx;
  logic             err, err_nx;
  logic             ovr, ovr_nx;       // clamp high (vs. clamp low) when err
  logic [8:0]       angle_nx;
  logic [CNT_W-1:0] width_nx;
  logic             range_err_nx;

  // One restoring step: trial-subtract SCALE<<step from the remainder.
  logic [63:0]      dsor;
  logic             ge;
  logic [CNT_W-1:0] rem_sub;

  assign dsor    = 64'(SCALE) << step;
  assign ge      = 64'(rem) >= dsor;
  assign rem_sub = CNT_W'(64'(rem) - dsor);

  always_comb begin
    state_nx     = state;
    cnt_nx       = cnt;
    width_r_nx   = width_r;
    rem_nx       = rem;
    q_nx         = q;
    step_nx      = step;
    err_nx       = err;
    ovr_nx       = ovr;
    angle_nx     = angle;
    width_nx     = width;
    range_err_nx = range_err;

    case (state)
      IDLE: begin
        if (rise) begin
          state_nx = HIGH;
          cnt_nx   = CNT_W'(1);
        end
      end
      HIGH: begin
        if (fall) begin
          width_r_nx = cnt;
          state_nx   = CALC;
        end else if (cnt != CMAX) begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      CALC: begin
        q_nx     = '0;
        step_nx  = 4'd8;
        state_nx = DIV;
        if (64'(width_r) < 64'(OFFSET)) begin
          err_nx = 1'b1;
          ovr_nx = 1'b0;
          rem_nx = '0;
        end else if (64'(width_r) >= BOUND) begin
          err_nx = 1'b1;
          ovr_nx = 1'b1;
          rem_nx = '0;
        end else begin
          err_nx = 1'b0;
          ovr_nx = 1'b0;
          rem_nx = CNT_W'(64'(width_r) - 64'(OFFSET));
        end
      end
      DIV: begin
        if (ge) begin
          rem_nx = rem_sub;
          q_nx   = q | (9'd1 << step);
        end
        if (step == 4'd0) begin
          // The last quotient bit is resolved this cycle. Load the outputs now
          // so that they are valid during DONE. A clamped value overrides q.
          state_nx     = DONE;
          angle_nx     = ovr ? AMAX : (err ? 9'd0 : q_nx);
          width_nx     = width_r;
          range_err_nx = err;
        end else begin
          step_nx = step - 4'd1;
        end
      end
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      width_r   <= '0;
      rem       <= '0;
      q         <= '0;
      step      <= '0;
      err       <= 1'b0;
      ovr       <= 1'b0;
      angle     <= '0;
      width     <= '0;
      range_err <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      width_r   <= width_r_nx;
      rem       <= rem_nx;
      q         <= q_nx;
      step      <= step_nx;
      err       <= err_nx;
      ovr       <= ovr_nx;
      angle     <= angle_nx;
      width     <= width_nx;
      range_err <= range_err_nx;
    end
  end

  assign angle_valid = (state == DONE);

  // ---------------------------------------------------------------------------
  // Loss-of-signal timer
  // ---------------------------------------------------------------------------
  // lcnt holds the number of cycles elapsed since the last rising edge, so it
  // reaches TIMEOUT exactly TIMEOUT cycles after R. The rise term masks the
  // flag during R itself, before the counter register restarts.
  logic [LW-1:0] lcnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           lcnt <= '0;
    else if (rise)        lcnt <= LW'(1);
    else if (lcnt != TMO) lcnt <= lcnt + LW'(1);
  end

  assign signal_lost = (lcnt == TMO) & ~rise;

endmodule

// File: tb/tb_servo_pulse_decoder.sv
// Directed bench for servo_pulse_decoder. It uses scaled-down parameters so that
// every case, including the loss timeout and counter saturation, runs in a few
// thousand cycles.
// Scaled mapping: width = 2*angle + 60. The legal range is 60..781 and the
// counter saturates at 1023.
module tb_servo_pulse_decoder;
  localparam int OFFSET  = 60;
  localparam int SCALE   = 2;
  localparam int MAXA    = 360;
  localparam int TIMEOUT = 1500;
  localparam int CW      = 10;
  // pin fall -> strobe: 2 synchronizer cycles + 11 cycles after F
  localparam int LAT     = 13;

  logic          clk = 1'b0, rst_n = 1'b0, pwm_in = 1'b0;
  logic [8:0]    angle;
  logic          angle_valid, range_err, signal_lost;
  logic [CW-1:0] width;

  servo_pulse_decoder #(.OFFSET(OFFSET), .SCALE(SCALE), .MAX_ANGLE(MAXA),
                        .TIMEOUT(TIMEOUT), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .pwm_in(pwm_in), .angle(angle),
    .angle_valid(angle_valid), .width(width), .range_err(range_err),
    .signal_lost(signal_lost));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // strobe monitor, sampled on the falling edge
  int nstb = 0, s_cyc = 0, s_ang = 0, s_w = 0, s_err = 0;
  always @(negedge clk) begin
    if (angle_valid) begin
      nstb  = nstb + 1;
      s_cyc = cyc;
      s_ang = int'(angle);
      s_w   = int'(width);
      s_err = int'(range_err);
    end
  end

  int ncmp = 0, nerr = 0;
  int rise_cyc = 0, fall_cyc = 0;

  task automatic chk(input string name, input int act, input int exp);
    ncmp++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic do_pulse(input int hi, input int lo);
    @(negedge clk);
    pwm_in = 1'b1; rise_cyc = cyc;
    repeat (hi) @(negedge clk);
    pwm_in = 1'b0; fall_cyc = cyc;
    repeat (lo) @(negedge clk);
  endtask

  task automatic check_pulse(input string name, input int hi, input int ang,
                             input int w, input int err);
    int n0;
    n0 = nstb;
    do_pulse(hi, 30);
    chk({name, " strobes"}, nstb - n0, 1);
    chk({name, " latency"}, s_cyc - fall_cyc, LAT);
    chk({name, " angle"}, s_ang, ang);
    chk({name, " width"}, s_w, w);
    chk({name, " range_err"}, s_err, err);
    chk({name, " angle hold"}, int'(angle), ang);
    chk({name, " signal_lost"}, int'(signal_lost), 0);
  endtask

  typedef struct {
    string name;
    int    hi;
    int    ang;
    int    w;
    int    err;
  } vec_t;

  vec_t tbl[8];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n0;
    tbl[0] = '{"a90",     240,   90,  240, 0};
    tbl[1] = '{"trunc",   241,   90,  241, 0};
    tbl[2] = '{"a0",       60,    0,   60, 0};
    tbl[3] = '{"a360",    780,  360,  780, 0};
    tbl[4] = '{"top",     781,  360,  781, 0};
    tbl[5] = '{"under",    59,    0,   59, 1};
    tbl[6] = '{"over",    782,  360,  782, 1};
    tbl[7] = '{"recover", 240,   90,  240, 0};

    // reset state
    repeat (3) @(negedge clk);
    chk("rst angle", int'(angle), 0);
    chk("rst width", int'(width), 0);
    chk("rst valid", int'(angle_valid), 0);
    chk("rst range_err", int'(range_err), 0);
    chk("rst signal_lost", int'(signal_lost), 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    foreach (tbl[i]) check_pulse(tbl[i].name, tbl[i].hi, tbl[i].ang, tbl[i].w, tbl[i].err);

    // loss of signal: last rise was for the 240 pulse
    while (cyc < rise_cyc + 1 + TIMEOUT) @(negedge clk);
    chk("lost before", int'(signal_lost), 0);
    @(negedge clk);
    chk("lost at timeout", int'(signal_lost), 1);
    chk("lost angle", int'(angle), 90);
    repeat (20) @(negedge clk);
    chk("lost held", int'(signal_lost), 1);
    pwm_in = 1'b1; rise_cyc = cyc;
    @(negedge clk);
    chk("lost pre-R", int'(signal_lost), 1);
    @(negedge clk);
    chk("lost clr at R", int'(signal_lost), 0);
    chk("lost clr angle", int'(angle), 90);
    n0 = nstb;
    repeat (238) @(negedge clk);
    pwm_in = 1'b0; fall_cyc = cyc;
    repeat (30) @(negedge clk);
    chk("post-lost strobes", nstb - n0, 1);
    chk("post-lost angle", s_ang, 90);
    chk("post-lost latency", s_cyc - fall_cyc, LAT);

    // stuck high past TIMEOUT and counter saturation
    n0 = nstb;
    @(negedge clk);
    pwm_in = 1'b1;
    repeat (1600) @(negedge clk);
    chk("stuck lost", int'(signal_lost), 1);
    chk("stuck no strobe", nstb - n0, 0);
    pwm_in = 1'b0; fall_cyc = cyc;
    repeat (30) @(negedge clk);
    chk("stuck strobes", nstb - n0, 1);
    chk("stuck width", s_w, 1023);
    chk("stuck angle", s_ang, 360);
    chk("stuck range_err", s_err, 1);

    // reset mid-HIGH
    @(negedge clk);
    pwm_in = 1'b1;
    repeat (100) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("arst angle", int'(angle), 0);
    chk("arst width", int'(width), 0);
    chk("arst range_err", int'(range_err), 0);
    chk("arst valid", int'(angle_valid), 0);
    chk("arst lost", int'(signal_lost), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    n0 = nstb;
    repeat (100) @(negedge clk);
    pwm_in = 1'b0;
    repeat (40) @(negedge clk);
    chk("arst skipped pulse", nstb - n0, 0);
    check_pulse("after rst", 240, 90, 240, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
